// File: rtl/param_rcu_if.sv
// rtl/param_rcu_if.sv - receive-line and control-output bundle for the UART receive control unit
interface param_rcu_if;
  logic start_bit_detected;
  logic serial_in;
  logic data_read;
  logic shift_strobe;
  logic enable_timer;
  logic load_buffer;
  logic data_ready;
  logic framing_error;
  logic parity_error;
  logic overrun_error;
  logic rx_busy;

  modport master (
    output start_bit_detected, serial_in, data_read,
    input  shift_strobe, enable_timer, load_buffer, data_ready,
    input  framing_error, parity_error, overrun_error, rx_busy
  );

  modport slave (
    input  start_bit_detected, serial_in, data_read,
    output shift_strobe, enable_timer, load_buffer, data_ready,
    output framing_error, parity_error, overrun_error, rx_busy
  );
endinterface

// File: rtl/param_rcu.sv
// rtl/param_rcu.sv - receive control unit: frames serial bits, strobes the shifter, loads the buffer, flags errors
module param_rcu #(
  parameter int NUM_DATA_BITS = 8,
  parameter int CLKS_PER_BIT  = 10,
  parameter bit PARITY_EN     = 1'b0,
  parameter bit PARITY_ODD    = 1'b0
) (
  input logic        clk,
  input logic        n_rst,
  param_rcu_if.slave rx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(NUM_DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(NUM_DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    LOAD   = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [BW-1:0] bit_cnt, bit_cnt_nxt;
  logic          xor_acc, xor_acc_nxt;
  logic          fe, fe_nxt, pe, pe_nxt, dr, dr_nxt, ov, ov_nxt;
  logic          tick, half_tick, shift, load, en, busy;

  assign tick      = (cnt == BIT_LAST);
  assign half_tick = (cnt == HALF_LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      xor_acc <= 1'b0;
      fe      <= 1'b0;
      pe      <= 1'b0;
      dr      <= 1'b0;
      ov      <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      xor_acc <= xor_acc_nxt;
      fe      <= fe_nxt;
      pe      <= pe_nxt;
      dr      <= dr_nxt;
      ov      <= ov_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    xor_acc_nxt = xor_acc;
    fe_nxt      = fe;
    pe_nxt      = pe;
    shift       = 1'b0;
    load        = 1'b0;
    en          = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (rx.start_bit_detected) state_nxt = START;
      end
      START: begin
        en = 1'b1;
        if (half_tick) begin
          bit_cnt_nxt = '0;
          xor_acc_nxt = 1'b0;
          if (!rx.serial_in) begin
            state_nxt = DATA;
            fe_nxt    = 1'b0;
            pe_nxt    = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        en = 1'b1;
        if (tick) begin
          shift       = 1'b1;
          bit_cnt_nxt = bit_cnt + 1'b1;
          xor_acc_nxt = xor_acc ^ rx.serial_in;
          if (bit_cnt == DATA_LAST) state_nxt = PARITY_EN ? PARITY : STOP;
        end
      end
      PARITY: begin
        en = 1'b1;
        if (tick) begin
          pe_nxt    = ((xor_acc ^ rx.serial_in) != PARITY_ODD);
          state_nxt = STOP;
        end
      end
      STOP: begin
        en = 1'b1;
        if (tick) begin
          if (rx.serial_in) begin
            state_nxt = LOAD;
          end else begin
            fe_nxt    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      LOAD: begin
        load      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Timer restarts on every state change and after each full-bit sample.
  always_comb begin
    cnt_nxt = cnt + 1'b1;
    if (state_nxt != state || state == IDLE || state == LOAD || tick) cnt_nxt = '0;
  end

  always_comb begin
    dr_nxt = dr;
    ov_nxt = ov;
    if (load)              dr_nxt = 1'b1;
    else if (rx.data_read) dr_nxt = 1'b0;
    if (load && dr && !rx.data_read) ov_nxt = 1'b1;
    else if (rx.data_read)           ov_nxt = 1'b0;
  end

  assign rx.shift_strobe  = shift;
  assign rx.enable_timer  = en;
  assign rx.load_buffer   = load;
  assign rx.data_ready    = dr;
  assign rx.framing_error = fe;
  assign rx.parity_error  = pe;
  assign rx.overrun_error = ov;
  assign rx.rx_busy       = busy;
endmodule

// File: tb/tb_param_rcu.sv
// tb/tb_param_rcu.sv - bench for param_rcu: frame table, randomized frames against a timing/flag model
`timescale 1ns/1ps
module tb_param_rcu;
  localparam int N = 8;

  logic clk = 1'b0;
  logic n_rst, sbd, sin, drd;
  always #5 clk = ~clk;

  param_rcu_if if0();
  param_rcu_if if1();
  assign if0.start_bit_detected = sbd;
  assign if0.serial_in          = sin;
  assign if0.data_read          = drd;
  assign if1.start_bit_detected = sbd;
  assign if1.serial_in          = sin;
  assign if1.data_read          = drd;

  param_rcu #(.NUM_DATA_BITS(N), .CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0))
    dut0 (.clk(clk), .n_rst(n_rst), .rx(if0.slave));
  param_rcu #(.NUM_DATA_BITS(N), .CLKS_PER_BIT(6), .PARITY_EN(1'b1), .PARITY_ODD(1'b0))
    dut1 (.clk(clk), .n_rst(n_rst), .rx(if1.slave));

  int cfg = 0;
  int clks = 4;
  bit par_en = 1'b0;
  bit m_dr, m_fe, m_pe, m_ov;
  int n_tests = 0;
  int n_fail = 0;

  // {shift_strobe, enable_timer, load_buffer, data_ready, framing_error, parity_error, overrun_error, rx_busy}
  logic [7:0] out0, out1, act;
  assign out0 = {if0.shift_strobe, if0.enable_timer, if0.load_buffer, if0.data_ready,
                 if0.framing_error, if0.parity_error, if0.overrun_error, if0.rx_busy};
  assign out1 = {if1.shift_strobe, if1.enable_timer, if1.load_buffer, if1.data_ready,
                 if1.framing_error, if1.parity_error, if1.overrun_error, if1.rx_busy};
  assign act = (cfg == 1) ? out1 : out0;

  typedef struct {
    int         cfg;
    logic [8:0] data;
    bit         par_bit;
    bit         stop_bit;
    bit         false_start;
    int         rd;          // 0 none, 1 data_read in start-pulse cycle, 2 data_read in load cycle
    logic [3:0] exp_flags;   // {data_ready, framing_error, parity_error, overrun_error}
  } vec_t;
  vec_t tbl [13];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic run_frame(input logic [8:0] data, input bit par_bit, input bit stop_bit,
                           input bit false_start, input int rd, input bit hold_sbd);
    bit   bits [0:15];
    int   h, nb, par_t, stop_t, load_t, last_busy, d, j;
    bit   xr, e_shift, e_en, e_load, e_busy;
    h = clks / 2;
    bits[0] = false_start;
    xr = 1'b0;
    for (int k = 0; k < N; k++) begin
      bits[k + 1] = data[k];
      xr ^= data[k];
    end
    nb = N + 1;
    if (par_en) begin
      bits[nb] = par_bit;
      nb++;
    end
    bits[nb] = stop_bit;
    nb++;
    par_t  = h + (N + 1) * clks;
    stop_t = h + (N + 1 + int'(par_en)) * clks;
    load_t = stop_t + 1;
    last_busy = false_start ? h : (stop_bit ? load_t : stop_t);
    for (int c = 0; c <= last_busy + 1; c++) begin
      sbd = (c == 0) || (hold_sbd && c > h && c <= h + 3 * clks);
      d = c - h;
      j = (d <= 0) ? 0 : (d + clks - 1) / clks;
      sin = (j < nb) ? bits[j] : 1'b1;
      drd = (rd == 1 && c == 0) || (rd == 2 && !false_start && stop_bit && c == load_t);
      e_shift = !false_start && c > h && c <= h + N * clks && ((c - h) % clks == 0);
      e_load  = !false_start && stop_bit && c == load_t;
      e_en    = c >= 1 && c <= (false_start ? h : stop_t);
      e_busy  = c >= 1 && c <= last_busy;
      @(negedge clk);
      check("frame_cycle", act, {e_shift, e_en, e_load, m_dr, m_fe, m_pe, m_ov, e_busy});
      @(posedge clk);
      if (!false_start && c == h) begin
        m_fe = 1'b0;
        m_pe = 1'b0;
      end
      if (!false_start && par_en && c == par_t) m_pe = (xr ^ par_bit);
      if (!false_start && c == stop_t && !stop_bit) m_fe = 1'b1;
      m_ov = (e_load && m_dr && !drd) ? 1'b1 : (drd ? 1'b0 : m_ov);
      m_dr = e_load ? 1'b1 : (drd ? 1'b0 : m_dr);
      #1;
    end
    sbd = 1'b0;
    drd = 1'b0;
    sin = 1'b1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    sbd = 1'b0;
    drd = 1'b0;
    sin = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", act, 8'h00);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    m_dr = 1'b0; m_fe = 1'b0; m_pe = 1'b0; m_ov = 1'b0;
  endtask

  task automatic run_cfg(input int sel);
    int rd;
    bit fs, stp;
    cfg = sel;
    clks = (sel == 1) ? 6 : 4;
    par_en = (sel == 1);
    do_reset();
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].cfg == sel) begin
        run_frame(tbl[i].data, tbl[i].par_bit, tbl[i].stop_bit, tbl[i].false_start, tbl[i].rd, 1'b0);
        @(negedge clk);
        check("table_flags", {4'b0, act[4:1]}, {4'b0, tbl[i].exp_flags});
        @(posedge clk);
        #1;
      end
    end
    for (int i = 0; i < 40; i++) begin
      fs  = ($urandom_range(0, 9) == 0);
      stp = ($urandom_range(0, 7) != 0);
      rd  = int'($urandom_range(0, 2));
      if (rd == 2 && (fs || !stp)) rd = 0;
      run_frame(9'($urandom), 1'($urandom), stp, fs, rd, ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    if (sel == 0) begin
      // Reset lands mid-DATA; afterwards a low line without a new pulse must not start a frame.
      sbd = 1'b1;
      sin = 1'b0;
      @(posedge clk);
      #1;
      sbd = 1'b0;
      repeat (clks / 2 + 5) @(posedge clk);
      #1;
      check("mid_data_busy", act & 8'b0100_0001, 8'b0100_0001);
      #2;
      n_rst = 1'b0;
      #1;
      check("reset_mid_data", act, 8'h00);
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      m_dr = 1'b0; m_fe = 1'b0; m_pe = 1'b0; m_ov = 1'b0;
      for (int c = 0; c < 3 * clks; c++) begin
        sin = c[0];
        @(negedge clk);
        check("no_frame_after_reset", act, 8'h00);
        @(posedge clk);
        #1;
      end
      sin = 1'b1;
      run_frame(9'h0C3, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    end
  endtask

  initial begin
    tbl[0]  = '{0, 9'h055, 1'b0, 1'b1, 1'b0, 0, 4'b1000};
    tbl[1]  = '{0, 9'h0AA, 1'b0, 1'b1, 1'b1, 0, 4'b1000};
    tbl[2]  = '{0, 9'h0A3, 1'b0, 1'b0, 1'b0, 0, 4'b1100};
    tbl[3]  = '{0, 9'h011, 1'b0, 1'b1, 1'b1, 0, 4'b1100};
    tbl[4]  = '{0, 9'h03C, 1'b0, 1'b1, 1'b0, 0, 4'b1001};
    tbl[5]  = '{0, 9'h0FF, 1'b0, 1'b1, 1'b0, 1, 4'b1000};
    tbl[6]  = '{0, 9'h000, 1'b0, 1'b1, 1'b0, 2, 4'b1000};
    tbl[7]  = '{0, 9'h081, 1'b0, 1'b1, 1'b0, 0, 4'b1001};
    tbl[8]  = '{0, 9'h000, 1'b0, 1'b1, 1'b1, 1, 4'b0000};
    tbl[9]  = '{1, 9'h007, 1'b0, 1'b1, 1'b0, 0, 4'b1010};
    tbl[10] = '{1, 9'h007, 1'b1, 1'b1, 1'b0, 1, 4'b1000};
    tbl[11] = '{1, 9'h05A, 1'b1, 1'b0, 1'b0, 0, 4'b1110};
    tbl[12] = '{1, 9'h05A, 1'b0, 1'b1, 1'b0, 0, 4'b1001};
    n_rst = 1'b0;
    sbd = 1'b0;
    sin = 1'b1;
    drd = 1'b0;
    run_cfg(0);
    run_cfg(1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/param_rcu.md
PARAM_RCU -- requirements
Module: param_rcu

Interface
REQ-001 Parameter NUM_DATA_BITS, default 8, data bits per frame, legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 10, clocks per serial bit, even, >= 4.
REQ-003 Parameter PARITY_EN, default 0, 1 = frame carries one parity bit after the data bits.
REQ-004 Parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
REQ-005 clk  in  1  system clock; all state updates on rising edge.
REQ-006 n_rst  in  1  asynchronous active-low reset.
REQ-007 start_bit_detected  in  1  one-cycle pulse from edge detector, falling edge on line.
REQ-008 serial_in  in  1  synchronised receive line, idle high.
REQ-009 data_read  in  1  consumer acknowledge of the loaded byte.
REQ-010 shift_strobe  out  1  one-cycle pulse to shift one data bit into the external shift register.
REQ-011 enable_timer  out  1  high while a frame is being timed.
REQ-012 load_buffer  out  1  one-cycle pulse to copy the shift register into the receive buffer.
REQ-013 data_ready  out  1  receive buffer holds an unread frame.
REQ-014 framing_error  out  1  last frame had a low stop bit.
REQ-015 parity_error  out  1  last frame failed parity.
REQ-016 overrun_error  out  1  frame loaded while previous one was unread.
REQ-017 rx_busy  out  1  controller not in IDLE.

Function
REQ-018 States SHALL be IDLE, START, DATA, PARITY, STOP, LOAD; rx_busy = (state != IDLE).
REQ-019 Bit timer cnt SHALL reset to 0 on every state change and in IDLE/LOAD, else increment by 1 per clock.
REQ-020 IDLE -> START when start_bit_detected = 1; start_bit_detected SHALL be ignored in all other states.
REQ-021 START: at cnt = CLKS_PER_BIT/2 - 1 sample serial_in; 0 -> DATA, 1 -> IDLE (false start, no flags changed).
REQ-022 DATA/PARITY/STOP: sample tick when cnt = CLKS_PER_BIT - 1; cnt then returns to 0.
REQ-023 In DATA, shift_strobe SHALL equal the sample tick; bit counter increments per tick, running XOR accumulates serial_in.
REQ-024 After the NUM_DATA_BITS-th DATA tick -> PARITY if PARITY_EN = 1, else STOP; bit counter and XOR cleared on leaving START.
REQ-025 PARITY tick: parity_error next value = ((XOR ^ serial_in) != PARITY_ODD); -> STOP.
REQ-026 STOP tick: serial_in = 1 -> LOAD; serial_in = 0 -> framing_error set, -> IDLE, no load_buffer.
REQ-027 LOAD: load_buffer = 1 for exactly one cycle, -> IDLE unconditionally; parity-failed frames are still loaded.
REQ-028 enable_timer = 1 in START, DATA, PARITY, STOP only.
REQ-029 framing_error and parity_error SHALL clear on the START -> DATA transition, else hold.
REQ-030 data_ready: set the cycle after load_buffer; cleared by data_read; set wins if both in one cycle.
REQ-031 overrun_error: set when load_buffer = 1 and data_ready = 1 and data_read = 0; cleared by data_read.
REQ-032 Unused state encodings SHALL return to IDLE next cycle with all pulse outputs low.

Reset
REQ-033 n_rst low SHALL force IDLE, cnt = 0, bit counter = 0, and all outputs 0 immediately, including mid-frame.
REQ-034 First frame after reset release SHALL require a fresh start_bit_detected.

Verification
REQ-035 Defaults, CLKS_PER_BIT = 4: start pulse cycle 0, line 0x55 LSB-first, stop 1 -> shift_strobe at cycles 6,10,...,34; load_buffer cycle 39; data_ready high from 40.
REQ-036 Start pulse then serial_in = 1 at the START sample -> return to IDLE, no shift_strobe, flags unchanged.
REQ-037 Stop bit 0 -> framing_error = 1, load_buffer never pulses, data_ready unchanged; next good frame clears framing_error.
REQ-038 PARITY_EN = 1, PARITY_ODD = 0, data 0x07, parity bit 0 -> parity_error = 1 and load_buffer still pulses; parity bit 1 -> parity_error = 0.
REQ-039 Two good frames with no data_read -> overrun_error = 1 after second load; data_read -> data_ready = 0, overrun_error = 0.
REQ-040 n_rst asserted in the middle of DATA -> all outputs 0 same cycle; start_bit_detected held high in DATA is ignored.
